// File: rtl/clock_set_ctrl_pkg.sv
// Shared types and constants for the clock setting controller.
package clock_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
  localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_HOUR  = 3'd1,
    SET_MIN   = 3'd2,
    SET_AHOUR = 3'd3,
    SET_AMIN  = 3'd4
  } set_state_t;

  function automatic logic [HOUR_W-1:0] next_hour(input logic [HOUR_W-1:0] h);
    return (h == MAX_HOUR) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [MIN_W-1:0] next_min(input logic [MIN_W-1:0] m);
    return (m == MAX_MIN) ? 6'd0 : m + 6'd1;
  endfunction

  function automatic logic is_edit(input set_state_t s);
    return (s != RUN);
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Time-counter load path, alarm registers and display blanking of the setting controller.
interface clock_set_ctrl_if;
  import clock_pkg::*;

  logic [HOUR_W-1:0] cur_hour;
  logic [MIN_W-1:0]  cur_min;
  logic              time_load;
  logic [HOUR_W-1:0] time_hour;
  logic [MIN_W-1:0]  time_min;
  logic [HOUR_W-1:0] alarm_hour;
  logic [MIN_W-1:0]  alarm_min;
  logic              alarm_en;
  logic              editing;
  logic              blank_hour;
  logic              blank_min;

  modport master (
    input  cur_hour, cur_min,
    output time_load, time_hour, time_min, alarm_hour, alarm_min,
           alarm_en, editing, blank_hour, blank_min
  );

  modport slave (
    output cur_hour, cur_min,
    input  time_load, time_hour, time_min, alarm_hour, alarm_min,
           alarm_en, editing, blank_hour, blank_min
  );

endinterface

// File: rtl/clock_set_ctrl_btn_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter and rising-edge pulse.
module btn_conditioner #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise_p
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [1:0]       sync_r;
  logic [CNT_W-1:0] cnt_r;
  logic             level_r;
  logic             rise_r;

  // Synchronize, then accept a new level once it has been stable long enough
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r  <= 2'b00;
      cnt_r   <= CNT_W'(0);
      level_r <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], raw};
      if (sync_r[1] != level_r) begin
        if (cnt_r == CNT_W'(DEBOUNCE_CYC - 1)) begin
          level_r <= sync_r[1];
          rise_r  <= sync_r[1];
          cnt_r   <= CNT_W'(0);
        end else begin
          rise_r <= 1'b0;
          cnt_r  <= cnt_r + CNT_W'(1);
        end
      end else begin
        rise_r <= 1'b0;
        cnt_r  <= CNT_W'(0);
      end
    end
  end

  assign level  = level_r;
  assign rise_p = rise_r;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode FSM for editing time and alarm with blinking field blanking.
// Optional INC auto-repeat in edit states is enabled by defining CLOCK_SET_AUTOREPEAT_EN.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int BLINK_DIV    = 12500000,
  parameter int REPEAT_DLY   = 25000000,
  parameter int REPEAT_PER   = 5000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_mode_raw,
  input  logic                  btn_inc_raw,
  clock_set_ctrl_if.master      bus
);

  localparam int BLINK_W = $clog2(BLINK_DIV + 1);

  logic mode_level_s, mode_p_s;
  logic inc_level_s, inc_p_s;
  logic rep_p_s;
  logic inc_s;

  set_state_t        state_r, state_n;
  logic [HOUR_W-1:0] sh_h_r, sh_h_n;
  logic [MIN_W-1:0]  sh_m_r, sh_m_n;
  logic              time_load_r, time_load_n;
  logic [HOUR_W-1:0] time_hour_r, time_hour_n;
  logic [MIN_W-1:0]  time_min_r, time_min_n;
  logic [HOUR_W-1:0] alarm_hour_r, alarm_hour_n;
  logic [MIN_W-1:0]  alarm_min_r, alarm_min_n;
  logic              alarm_en_r, alarm_en_n;
  logic [BLINK_W-1:0] blink_cnt_r, blink_cnt_n;
  logic              phase_off_r, phase_off_n;
  logic              editing_r, blank_hour_r, blank_min_r;
  logic              blank_hour_n, blank_min_n;

  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode (
    .clk(clk), .rst(rst), .raw(btn_mode_raw), .level(mode_level_s), .rise_p(mode_p_s)
  );

  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc (
    .clk(clk), .rst(rst), .raw(btn_inc_raw), .level(inc_level_s), .rise_p(inc_p_s)
  );

`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_r;
  logic             rep_armed_r;
  logic             rep_p_r;
  logic             unused_s;

  // Auto-repeat timer: initial hold delay, then a fixed period while INC stays held
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_r   <= REP_W'(0);
      rep_armed_r <= 1'b0;
      rep_p_r     <= 1'b0;
    end else if (!inc_level_s || !is_edit(state_r) || (state_n != state_r)) begin
      rep_cnt_r   <= REP_W'(0);
      rep_armed_r <= 1'b0;
      rep_p_r     <= 1'b0;
    end else if (!rep_armed_r && (rep_cnt_r == REP_W'(REPEAT_DLY - 1))) begin
      rep_cnt_r   <= REP_W'(0);
      rep_armed_r <= 1'b1;
      rep_p_r     <= 1'b1;
    end else if (rep_armed_r && (rep_cnt_r == REP_W'(REPEAT_PER - 1))) begin
      rep_cnt_r   <= REP_W'(0);
      rep_armed_r <= 1'b1;
      rep_p_r     <= 1'b1;
    end else begin
      rep_cnt_r   <= rep_cnt_r + REP_W'(1);
      rep_armed_r <= rep_armed_r;
      rep_p_r     <= 1'b0;
    end
  end

  assign rep_p_s  = rep_p_r;
  assign unused_s = &{1'b0, mode_level_s};
`else
  logic unused_s;
  assign rep_p_s  = 1'b0;
  assign unused_s = &{1'b0, mode_level_s, inc_level_s, REPEAT_DLY[0], REPEAT_PER[0]};
`endif

  assign inc_s = inc_p_s | rep_p_s;

  // Next-state, shadow, alarm and blink computation; MODE takes priority over INC
  always_comb begin
    state_n      = state_r;
    sh_h_n       = sh_h_r;
    sh_m_n       = sh_m_r;
    time_load_n  = 1'b0;
    alarm_hour_n = alarm_hour_r;
    alarm_min_n  = alarm_min_r;
    alarm_en_n   = alarm_en_r;
    time_hour_n  = time_hour_r;
    time_min_n   = time_min_r;
    blink_cnt_n  = blink_cnt_r;
    phase_off_n  = phase_off_r;

    case (state_r)
      RUN: begin
        if (mode_p_s) begin
          state_n = SET_HOUR;
          sh_h_n  = bus.cur_hour;
          sh_m_n  = bus.cur_min;
        end else if (inc_p_s) begin
          alarm_en_n = ~alarm_en_r;
        end else begin
          alarm_en_n = alarm_en_r;
        end
      end
      SET_HOUR, SET_AHOUR: begin
        if (mode_p_s) begin
          state_n = (state_r == SET_HOUR) ? SET_MIN : SET_AMIN;
        end else if (inc_s) begin
          sh_h_n = next_hour(sh_h_r);
        end else begin
          sh_h_n = sh_h_r;
        end
      end
      SET_MIN: begin
        if (mode_p_s) begin
          state_n     = SET_AHOUR;
          time_load_n = 1'b1;
          sh_h_n      = alarm_hour_r;
          sh_m_n      = alarm_min_r;
        end else if (inc_s) begin
          sh_m_n = next_min(sh_m_r);
        end else begin
          sh_m_n = sh_m_r;
        end
      end
      SET_AMIN: begin
        if (mode_p_s) begin
          state_n      = RUN;
          alarm_hour_n = sh_h_r;
          alarm_min_n  = sh_m_r;
        end else if (inc_s) begin
          sh_m_n = next_min(sh_m_r);
        end else begin
          sh_m_n = sh_m_r;
        end
      end
      default: begin
        state_n = RUN;
      end
    endcase

    // The load strobe carries the time shadows even though the shadows switch to the alarm
    if (time_load_n) begin
      time_hour_n = sh_h_r;
      time_min_n  = sh_m_r;
    end else if (is_edit(state_n)) begin
      time_hour_n = sh_h_n;
      time_min_n  = sh_m_n;
    end else begin
      time_hour_n = time_hour_r;
      time_min_n  = time_min_r;
    end

    if ((state_n != state_r) || !is_edit(state_r) || inc_s) begin
      blink_cnt_n = BLINK_W'(0);
      phase_off_n = 1'b0;
    end else if (blink_cnt_r == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_n = BLINK_W'(0);
      phase_off_n = ~phase_off_r;
    end else begin
      blink_cnt_n = blink_cnt_r + BLINK_W'(1);
      phase_off_n = phase_off_r;
    end

    blank_hour_n = phase_off_n && ((state_n == SET_HOUR) || (state_n == SET_AHOUR));
    blank_min_n  = phase_off_n && ((state_n == SET_MIN)  || (state_n == SET_AMIN));
  end

  // Controller state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= RUN;
      sh_h_r       <= 5'd0;
      sh_m_r       <= 6'd0;
      time_load_r  <= 1'b0;
      time_hour_r  <= 5'd0;
      time_min_r   <= 6'd0;
      alarm_hour_r <= 5'd0;
      alarm_min_r  <= 6'd0;
      alarm_en_r   <= 1'b0;
      blink_cnt_r  <= BLINK_W'(0);
      phase_off_r  <= 1'b0;
      editing_r    <= 1'b0;
      blank_hour_r <= 1'b0;
      blank_min_r  <= 1'b0;
    end else begin
      state_r      <= state_n;
      sh_h_r       <= sh_h_n;
      sh_m_r       <= sh_m_n;
      time_load_r  <= time_load_n;
      time_hour_r  <= time_hour_n;
      time_min_r   <= time_min_n;
      alarm_hour_r <= alarm_hour_n;
      alarm_min_r  <= alarm_min_n;
      alarm_en_r   <= alarm_en_n;
      blink_cnt_r  <= blink_cnt_n;
      phase_off_r  <= phase_off_n;
      editing_r    <= is_edit(state_n);
      blank_hour_r <= blank_hour_n;
      blank_min_r  <= blank_min_n;
    end
  end

  assign bus.time_load  = time_load_r;
  assign bus.time_hour  = time_hour_r;
  assign bus.time_min   = time_min_r;
  assign bus.alarm_hour = alarm_hour_r;
  assign bus.alarm_min  = alarm_min_r;
  assign bus.alarm_en   = alarm_en_r;
  assign bus.editing    = editing_r;
  assign bus.blank_hour = blank_hour_r;
  assign bus.blank_min  = blank_min_r;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl with short debounce and blink periods.
module tb_clock_set_ctrl;
  import clock_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_mode_raw = 1'b0;
  logic btn_inc_raw = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   load_cnt = 0;
  int   load_h = 0;
  int   load_m = 0;

  clock_set_ctrl_if bus_if();

  clock_set_ctrl #(
    .DEBOUNCE_CYC(4), .BLINK_DIV(8), .REPEAT_DLY(20), .REPEAT_PER(5)
  ) dut (
    .clk(clk), .rst(rst), .btn_mode_raw(btn_mode_raw), .btn_inc_raw(btn_inc_raw), .bus(bus_if)
  );

  always #5 clk = ~clk;

  // Record every load strobe the time counter would see
  always @(posedge clk) begin
    if (bus_if.time_load === 1'b1) begin
      load_cnt <= load_cnt + 1;
      load_h   <= int'(bus_if.time_hour);
      load_m   <= int'(bus_if.time_min);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    btn_mode_raw = 1'b1;
    repeat (10) tick();
    btn_mode_raw = 1'b0;
    repeat (10) tick();
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      btn_inc_raw = 1'b1;
      repeat (10) tick();
      btn_inc_raw = 1'b0;
      repeat (10) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++; if (bus_if.editing !== 1'b0) begin errors++; $display("FAIL reset_editing: got %0b expected 0", bus_if.editing); end
    checks++; if ({bus_if.time_hour, bus_if.time_min} !== 11'd0) begin errors++; $display("FAIL reset_time: got %0d:%0d expected 0:0", bus_if.time_hour, bus_if.time_min); end
    checks++; if ({bus_if.alarm_hour, bus_if.alarm_min, bus_if.alarm_en} !== 12'd0) begin errors++; $display("FAIL reset_alarm: got %0d:%0d en %0b expected 0:0 en 0", bus_if.alarm_hour, bus_if.alarm_min, bus_if.alarm_en); end
    checks++; if ({bus_if.time_load, bus_if.blank_hour, bus_if.blank_min} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %0b expected 000", {bus_if.time_load, bus_if.blank_hour, bus_if.blank_min}); end
  endtask

  task automatic test_edit_time();
    bus_if.cur_hour = 5'd10;
    bus_if.cur_min  = 6'd15;
    tick();
    press_mode();
    checks++; if (bus_if.editing !== 1'b1) begin errors++; $display("FAIL edit_enter: editing got %0b expected 1", bus_if.editing); end
    checks++; if ({bus_if.time_hour, bus_if.time_min} !== {5'd10, 6'd15}) begin errors++; $display("FAIL edit_capture: got %0d:%0d expected 10:15", bus_if.time_hour, bus_if.time_min); end
    press_inc(3);
    checks++; if (bus_if.time_hour !== 5'd13) begin errors++; $display("FAIL edit_hour: got %0d expected 13", bus_if.time_hour); end
    press_mode();
    press_inc(2);
    checks++; if (bus_if.time_min !== 6'd17) begin errors++; $display("FAIL edit_min: got %0d expected 17", bus_if.time_min); end
    checks++; if (load_cnt !== 0) begin errors++; $display("FAIL edit_no_early_load: got %0d loads expected 0", load_cnt); end
    press_mode();
    checks++; if (load_cnt !== 1) begin errors++; $display("FAIL edit_load_count: got %0d expected 1", load_cnt); end
    checks++; if ((load_h !== 13) || (load_m !== 17)) begin errors++; $display("FAIL edit_load_value: got %0d:%0d expected 13:17", load_h, load_m); end
    checks++; if (dut.state_r !== SET_AHOUR) begin errors++; $display("FAIL edit_state: got %0d expected %0d", dut.state_r, SET_AHOUR); end
  endtask

  task automatic test_alarm();
    press_inc(7);
    press_mode();
    press_inc(45);
    press_mode();
    checks++; if ({bus_if.alarm_hour, bus_if.alarm_min} !== {5'd7, 6'd45}) begin errors++; $display("FAIL alarm_value: got %0d:%0d expected 7:45", bus_if.alarm_hour, bus_if.alarm_min); end
    checks++; if (bus_if.editing !== 1'b0) begin errors++; $display("FAIL alarm_run: editing got %0b expected 0", bus_if.editing); end
    checks++; if (load_cnt !== 1) begin errors++; $display("FAIL alarm_no_load: got %0d loads expected 1", load_cnt); end
    press_inc(1);
    checks++; if (bus_if.alarm_en !== 1'b1) begin errors++; $display("FAIL alarm_en_on: got %0b expected 1", bus_if.alarm_en); end
    press_inc(1);
    checks++; if (bus_if.alarm_en !== 1'b0) begin errors++; $display("FAIL alarm_en_off: got %0b expected 0", bus_if.alarm_en); end
  endtask

  task automatic test_wrap();
    bus_if.cur_hour = 5'd23;
    bus_if.cur_min  = 6'd59;
    press_mode();
    press_inc(1);
    checks++; if ({bus_if.time_hour, bus_if.time_min} !== {5'd0, 6'd59}) begin errors++; $display("FAIL wrap_hour: got %0d:%0d expected 0:59", bus_if.time_hour, bus_if.time_min); end
    press_mode();
    press_inc(1);
    checks++; if ({bus_if.time_hour, bus_if.time_min} !== {5'd0, 6'd0}) begin errors++; $display("FAIL wrap_min: got %0d:%0d expected 0:0", bus_if.time_hour, bus_if.time_min); end
  endtask

  task automatic test_blink();
    int   waited;
    int   bad_hold;
    int   bad_hour;
    logic prev;
    logic [5:0] m0;
    // Find the start of an off phase
    waited = 0;
    prev = bus_if.blank_min;
    tick();
    while (!(bus_if.blank_min === 1'b1 && prev === 1'b0) && waited < 40) begin
      prev = bus_if.blank_min;
      tick();
      waited++;
    end
    checks++; if (waited >= 40) begin errors++; $display("FAIL blink_start: no blank_min rise within %0d cycles expected <40", waited); end
    bad_hold = 0;
    bad_hour = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus_if.blank_min !== 1'b1) bad_hold++;
      if (bus_if.blank_hour !== 1'b0) bad_hour++;
    end
    checks++; if (bad_hold != 0) begin errors++; $display("FAIL blink_hold: blank_min dropped in %0d of 7 cycles expected 0", bad_hold); end
    tick();
    checks++; if (bus_if.blank_min !== 1'b0) begin errors++; $display("FAIL blink_toggle: got %0b expected 0 after 8 cycles", bus_if.blank_min); end
    for (int i = 0; i < 8; i++) begin
      if (bus_if.blank_hour !== 1'b0) bad_hour++;
      tick();
    end
    checks++; if (bus_if.blank_min !== 1'b1) begin errors++; $display("FAIL blink_reoff: got %0b expected 1 after 8 on cycles", bus_if.blank_min); end
    checks++; if (bad_hour != 0) begin errors++; $display("FAIL blink_hour_idle: blank_hour set in %0d cycles expected 0", bad_hour); end
    // INC during the first off cycle must force the field visible when the value changes
    m0 = bus_if.time_min;
    btn_inc_raw = 1'b1;
    waited = 0;
    tick();
    while (bus_if.time_min === m0 && waited < 20) begin
      tick();
      waited++;
    end
    checks++; if (waited >= 20) begin errors++; $display("FAIL blink_inc_timeout: time_min stuck at %0d expected %0d", bus_if.time_min, m0 + 6'd1); end
    checks++; if (bus_if.blank_min !== 1'b0) begin errors++; $display("FAIL blink_inc_force: blank_min got %0b expected 0", bus_if.blank_min); end
    btn_inc_raw = 1'b0;
    repeat (10) tick();
    checks++; if (bus_if.time_min !== 6'd1) begin errors++; $display("FAIL blink_inc_value: got %0d expected 1", bus_if.time_min); end
  endtask

  task automatic test_debounce_simul();
    btn_inc_raw = 1'b1;
    repeat (2) tick();
    btn_inc_raw = 1'b0;
    repeat (12) tick();
    checks++; if (bus_if.time_min !== 6'd1) begin errors++; $display("FAIL glitch: time_min got %0d expected 1", bus_if.time_min); end
    btn_mode_raw = 1'b1;
    btn_inc_raw  = 1'b1;
    repeat (10) tick();
    btn_mode_raw = 1'b0;
    btn_inc_raw  = 1'b0;
    repeat (10) tick();
    checks++; if (dut.state_r !== SET_AHOUR) begin errors++; $display("FAIL simul_state: got %0d expected %0d", dut.state_r, SET_AHOUR); end
    checks++; if ((load_cnt !== 2) || (load_h !== 0) || (load_m !== 1)) begin errors++; $display("FAIL simul_load: got %0d loads %0d:%0d expected 2 loads 0:1", load_cnt, load_h, load_m); end
    checks++; if ({bus_if.time_hour, bus_if.time_min} !== {5'd7, 6'd45}) begin errors++; $display("FAIL simul_shadow: got %0d:%0d expected 7:45", bus_if.time_hour, bus_if.time_min); end
  endtask

  task automatic test_reset_mid_edit();
    press_mode();
    press_mode();
    checks++; if ({bus_if.editing, bus_if.alarm_hour, bus_if.alarm_min} !== {1'b0, 5'd7, 6'd45}) begin errors++; $display("FAIL back_to_run: got ed %0b %0d:%0d expected ed 0 7:45", bus_if.editing, bus_if.alarm_hour, bus_if.alarm_min); end
    bus_if.cur_hour = 5'd5;
    bus_if.cur_min  = 6'd28;
    press_mode();
    press_mode();
    press_inc(2);
    checks++; if (bus_if.time_min !== 6'd30) begin errors++; $display("FAIL mid_edit_min: got %0d expected 30", bus_if.time_min); end
    btn_mode_raw = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    btn_mode_raw = 1'b0;
    repeat (12) tick();
    checks++; if (load_cnt !== 2) begin errors++; $display("FAIL mid_reset_load: got %0d loads expected 2", load_cnt); end
    checks++; if (dut.state_r !== RUN) begin errors++; $display("FAIL mid_reset_state: got %0d expected %0d", dut.state_r, RUN); end
    checks++; if ({bus_if.time_hour, bus_if.time_min, bus_if.alarm_hour, bus_if.alarm_min, bus_if.alarm_en, bus_if.editing, bus_if.blank_hour, bus_if.blank_min, bus_if.time_load} !== 27'd0) begin errors++; $display("FAIL mid_reset_outputs: got %0h expected 0", {bus_if.time_hour, bus_if.time_min, bus_if.alarm_hour, bus_if.alarm_min, bus_if.alarm_en, bus_if.editing, bus_if.blank_hour, bus_if.blank_min, bus_if.time_load}); end
  endtask

  initial begin
    bus_if.cur_hour = 5'd0;
    bus_if.cur_min  = 6'd0;
    test_reset();
    test_edit_time();
    test_alarm();
    test_wrap();
    test_blink();
    test_debounce_simul();
    test_reset_mid_edit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
